// File: rtl/timer_irq_ctrl_pkg.sv
// timer_irq_pkg: shared constants and types for the timer/interrupt controller.
//   REG_*          word offsets from BASE_ADDR of the register map
//   IRQ_NONE       IRQ number reported when no unmasked source is pending
//   bus_req_t      decoded bus access (accepted, write, word offset)
package timer_irq_pkg;

    localparam int REG_PENDING      = 0;
    localparam int REG_MASK         = 1;
    localparam int REG_TIMER_ENABLE = 2;
    localparam int REG_TIMER_MODE   = 3;
    // Timer i: RELOAD at REG_TIMER_BASE+2i, COUNT at REG_TIMER_BASE+2i+1
    localparam int REG_TIMER_BASE   = 4;

    localparam logic [7:0] IRQ_NONE = 8'd0;

    typedef struct packed {
        logic        hit;   // access accepted (address inside the map)
        logic        wr;    // accepted write
        logic [15:0] off;   // word offset from BASE_ADDR
    } bus_req_t;

endpackage

// File: rtl/timer_irq_ctrl_timer_channel.sv
// timer_channel: one countdown timer.
//   I_clk, I_reset   clock, synchronous active-high reset
//   enable           count while set; clear freezes count
//   mode             0 one-shot, 1 auto-reload
//   reload           value reloaded on expiry in auto-reload mode
//   load, load_val   bus write strobe/value; wins over the decrement
//   count            current counter value
//   expire           high for the cycle in which count steps off 1
module timer_channel
#(
    parameter int WIDTH = 16
)
(
    input  logic             I_clk,
    input  logic             I_reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] reload,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    // A load in the same cycle replaces the expiring step entirely.
    assign expire = enable && !load && (count == WIDTH'(1));

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (expire) begin
            // reload==0 in auto-reload mode lands on 0 and idles there.
            count <= mode ? reload : '0;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: register-mapped interrupt controller with NUM_TIMERS
// countdown timers and NUM_EXT rising-edge external lines.
//   I_clk, I_reset            clock, synchronous active-high reset
//   I_exec/I_write/I_addr/I_data   bus access strobe, direction, address, data
//   O_data/O_data_ready       read data and one-cycle completion pulse
//   I_ext_irq                 external requests (edge detected)
//   I_irq_ack                 core acknowledge pulse
//   O_irq_active              any unmasked pending source
//   O_irq_num/O_irq_num_valid serviced IRQ number (source+1, 0 = none)
// Source s < NUM_EXT is external s, NUM_EXT+i is timer i; lower index wins.
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          NUM_EXT    = 2,
    parameter int          WIDTH      = 16,
    parameter logic [15:0] BASE_ADDR  = 16'hFF10
)
(
    input  logic               I_clk,
    input  logic               I_reset,
    input  logic               I_exec,
    input  logic               I_write,
    input  logic [15:0]        I_addr,
    input  logic [WIDTH-1:0]   I_data,
    output logic [WIDTH-1:0]   O_data,
    output logic               O_data_ready,
    input  logic [NUM_EXT-1:0] I_ext_irq,
    input  logic               I_irq_ack,
    output logic               O_irq_active,
    output logic [7:0]         O_irq_num,
    output logic               O_irq_num_valid
);

    localparam int NS        = NUM_EXT + NUM_TIMERS;
    localparam int MAP_WORDS = REG_TIMER_BASE + 2 * NUM_TIMERS;

    bus_req_t                              req;
    logic [NS-1:0]                         pending, mask, active_vec;
    logic [NS-1:0]                         set_vec, w1c_vec, ack_vec, ack_clr;
    logic [NUM_EXT-1:0]                    ext_prev;
    logic [NUM_TIMERS-1:0]                 tmr_en, tmr_mode, tmr_expire, tmr_load;
    logic [NUM_TIMERS-1:0][WIDTH-1:0]      tmr_reload, tmr_count;
    logic [WIDTH-1:0]                      rdata;
    logic [7:0]                            ack_num;

    // Addresses below BASE_ADDR wrap to a large offset and fall outside.
    assign req.off = I_addr - BASE_ADDR;
    assign req.hit = I_exec && (req.off < 16'(MAP_WORDS));
    assign req.wr  = req.hit && I_write;

    assign w1c_vec    = (req.wr && req.off == 16'(REG_PENDING)) ? I_data[NS-1:0] : '0;
    assign set_vec    = {tmr_expire, I_ext_irq & ~ext_prev};
    assign active_vec = pending & mask;
    assign ack_clr    = I_irq_ack ? ack_vec : '0;
    assign O_irq_active = |active_vec;

    // Priority encoder: descending scan so the lowest set index is kept.
    always_comb begin
        ack_vec = '0;
        ack_num = IRQ_NONE;
        for (int s = NS - 1; s >= 0; s--) begin
            if (active_vec[s]) begin
                ack_vec    = '0;
                ack_vec[s] = 1'b1;
                ack_num    = 8'(s + 1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (req.off == 16'(REG_PENDING))           rdata[NS-1:0] = pending;
        else if (req.off == 16'(REG_MASK))         rdata[NS-1:0] = mask;
        else if (req.off == 16'(REG_TIMER_ENABLE)) rdata[NUM_TIMERS-1:0] = tmr_en;
        else if (req.off == 16'(REG_TIMER_MODE))   rdata[NUM_TIMERS-1:0] = tmr_mode;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (req.off == 16'(REG_TIMER_BASE + 2 * i))     rdata = tmr_reload[i];
            if (req.off == 16'(REG_TIMER_BASE + 2 * i + 1)) rdata = tmr_count[i];
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
        // Writing RELOAD or COUNT both load the counter with the written value.
        assign tmr_load[i] = req.wr && (req.off == 16'(REG_TIMER_BASE + 2 * i) ||
                                        req.off == 16'(REG_TIMER_BASE + 2 * i + 1));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .I_clk    (I_clk),
            .I_reset  (I_reset),
            .enable   (tmr_en[i]),
            .mode     (tmr_mode[i]),
            .reload   (tmr_reload[i]),
            .load     (tmr_load[i]),
            .load_val (I_data),
            .count    (tmr_count[i]),
            .expire   (tmr_expire[i])
        );
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            pending         <= '0;
            mask            <= '0;
            ext_prev        <= '0;
            tmr_en          <= '0;
            tmr_mode        <= '0;
            tmr_reload      <= '0;
            O_data          <= '0;
            O_data_ready    <= 1'b0;
            O_irq_num       <= IRQ_NONE;
            O_irq_num_valid <= 1'b0;
        end else begin
            ext_prev <= I_ext_irq;
            // New events are OR-ed in last so they beat a same-cycle clear.
            pending  <= (pending & ~w1c_vec & ~ack_clr) | set_vec;
            if (req.wr && req.off == 16'(REG_MASK))         mask     <= I_data[NS-1:0];
            if (req.wr && req.off == 16'(REG_TIMER_ENABLE)) tmr_en   <= I_data[NUM_TIMERS-1:0];
            if (req.wr && req.off == 16'(REG_TIMER_MODE))   tmr_mode <= I_data[NUM_TIMERS-1:0];
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (req.wr && req.off == 16'(REG_TIMER_BASE + 2 * i)) tmr_reload[i] <= I_data;
            end
            O_data_ready    <= req.hit;
            O_data          <= (req.hit && !I_write) ? rdata : '0;
            O_irq_num_valid <= I_irq_ack;
            if (I_irq_ack) O_irq_num <= ack_num;
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl (2 timers, 2 external lines, 16-bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFF10;

    logic        I_clk = 1'b0;
    logic        I_reset, I_exec, I_write, I_irq_ack;
    logic [15:0] I_addr, I_data, O_data;
    logic        O_data_ready, O_irq_active, O_irq_num_valid;
    logic [1:0]  I_ext_irq;
    logic [7:0]  O_irq_num;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] rd;
    logic        rdy;

    timer_irq_ctrl #(
        .NUM_TIMERS(2), .NUM_EXT(2), .WIDTH(16), .BASE_ADDR(BASE)
    ) dut (
        .I_clk           (I_clk),
        .I_reset         (I_reset),
        .I_exec          (I_exec),
        .I_write         (I_write),
        .I_addr          (I_addr),
        .I_data          (I_data),
        .O_data          (O_data),
        .O_data_ready    (O_data_ready),
        .I_ext_irq       (I_ext_irq),
        .I_irq_ack       (I_irq_ack),
        .O_irq_active    (O_irq_active),
        .O_irq_num       (O_irq_num),
        .O_irq_num_valid (O_irq_num_valid)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus access: strobe for one cycle, capture the response one cycle later.
    task automatic bus(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        I_exec  = 1'b1;
        I_write = wr;
        I_addr  = addr;
        I_data  = data;
        @(negedge I_clk);
        rd      = O_data;
        rdy     = O_data_ready;
        I_exec  = 1'b0;
        I_write = 1'b0;
    endtask

    task automatic wr_reg(input int off, input logic [15:0] data);
        bus(1'b1, 16'(BASE + off), data);
        chk("wr_rdy", 32'(rdy), 1);
        chk("wr_data0", 32'(rd), 0);
    endtask

    task automatic rd_reg(input int off, input logic [15:0] exp, input string tag);
        bus(1'b0, 16'(BASE + off), 16'h0);
        chk({tag, "_rdy"}, 32'(rdy), 1);
        chk(tag, 32'(rd), 32'(exp));
    endtask

    task automatic ack(input logic [7:0] exp, input string tag);
        I_irq_ack = 1'b1;
        @(negedge I_clk);
        I_irq_ack = 1'b0;
        chk({tag, "_vld"}, 32'(O_irq_num_valid), 1);
        chk({tag, "_num"}, 32'(O_irq_num), 32'(exp));
        @(negedge I_clk);
        chk({tag, "_vld_drop"}, 32'(O_irq_num_valid), 0);
        chk({tag, "_num_hold"}, 32'(O_irq_num), 32'(exp));
    endtask

    initial begin
        I_reset = 1'b1; I_exec = 1'b0; I_write = 1'b0; I_irq_ack = 1'b0;
        I_addr = '0; I_data = '0; I_ext_irq = '0;
        repeat (3) @(negedge I_clk);
        chk("rst_ready",  32'(O_data_ready), 0);
        chk("rst_valid",  32'(O_irq_num_valid), 0);
        chk("rst_num",    32'(O_irq_num), 0);
        chk("rst_active", 32'(O_irq_active), 0);
        chk("rst_data",   32'(O_data), 0);
        I_reset = 1'b0;
        @(negedge I_clk);

        // Reset register values and single-cycle completion pulse
        rd_reg(1, 16'h0, "mask_rst");
        rd_reg(0, 16'h0, "pend_rst");
        @(negedge I_clk);
        chk("ready_pulse", 32'(O_data_ready), 0);
        chk("active_rst", 32'(O_irq_active), 0);

        // One-shot timer 0, reload 5: expiry 5 cycles after enable completes
        wr_reg(1, 16'h000F);
        wr_reg(3, 16'h0000);
        wr_reg(4, 16'd5);
        rd_reg(5, 16'd5, "cnt0_loaded");
        wr_reg(2, 16'h0001);
        repeat (4) @(negedge I_clk);
        chk("t0_not_yet", 32'(O_irq_active), 0);
        @(negedge I_clk);
        chk("t0_expired", 32'(O_irq_active), 1);
        rd_reg(0, 16'h0004, "pend_t0");
        rd_reg(5, 16'h0000, "cnt0_after");
        wr_reg(0, 16'h0004);
        repeat (20) @(negedge I_clk);
        rd_reg(0, 16'h0000, "t0_no_second");
        rd_reg(5, 16'h0000, "cnt0_idle");
        wr_reg(2, 16'h0000);

        // Auto-reload timer 1, reload 3: period 3; set beats same-cycle W1C
        wr_reg(3, 16'h0002);
        wr_reg(6, 16'd3);
        wr_reg(2, 16'h0002);
        repeat (2) @(negedge I_clk);
        chk("t1_not_yet", 32'(O_irq_active), 0);
        @(negedge I_clk);
        chk("t1_exp1", 32'(O_irq_active), 1);
        repeat (2) @(negedge I_clk);
        wr_reg(0, 16'h0008);                  // lands on the second expiry
        chk("w1c_vs_set", 32'(O_irq_active), 1);
        wr_reg(0, 16'h0008);                  // quiet cycle: clears
        chk("w1c_clear", 32'(O_irq_active), 0);
        @(negedge I_clk);
        chk("t1_gap", 32'(O_irq_active), 0);
        @(negedge I_clk);
        chk("t1_exp3", 32'(O_irq_active), 1);
        wr_reg(2, 16'h0000);
        wr_reg(0, 16'h000F);
        chk("t1_cleared", 32'(O_irq_active), 0);

        // Two external edges together, acked in priority order
        wr_reg(1, 16'h0003);
        I_ext_irq = 2'b11;
        @(negedge I_clk);
        I_ext_irq = 2'b00;
        chk("ext_active", 32'(O_irq_active), 1);
        ack(8'd1, "ack1");
        ack(8'd2, "ack2");
        ack(8'd0, "ack3");
        chk("ext_active_end", 32'(O_irq_active), 0);

        // Held level sets once; masked source still latches
        wr_reg(1, 16'h0000);
        I_ext_irq = 2'b01;
        repeat (3) @(negedge I_clk);
        rd_reg(0, 16'h0001, "pend_masked");
        chk("masked_inactive", 32'(O_irq_active), 0);
        ack(8'd0, "ack_masked");
        rd_reg(0, 16'h0001, "pend_after_mack");
        wr_reg(0, 16'h0001);
        repeat (3) @(negedge I_clk);
        rd_reg(0, 16'h0000, "pend_held");
        I_ext_irq = 2'b00;

        // Reset mid-count (COUNT=3) with an ack and a read in flight
        wr_reg(1, 16'h000F);
        wr_reg(3, 16'h0000);
        wr_reg(4, 16'd5);
        wr_reg(2, 16'h0001);
        repeat (2) @(negedge I_clk);
        I_reset = 1'b1; I_irq_ack = 1'b1;
        I_exec = 1'b1; I_write = 1'b0; I_addr = 16'(BASE + 1);
        @(negedge I_clk);
        chk("rst_mid_ready", 32'(O_data_ready), 0);
        chk("rst_mid_valid", 32'(O_irq_num_valid), 0);
        I_reset = 1'b0; I_irq_ack = 1'b0; I_exec = 1'b0;
        rd_reg(5, 16'h0000, "cnt0_rst");
        rd_reg(0, 16'h0000, "pend_rst2");
        rd_reg(1, 16'h0000, "mask_rst2");
        repeat (5) @(negedge I_clk);
        rd_reg(0, 16'h0000, "no_expiry");
        rd_reg(2, 16'h0000, "en_rst2");

        // Map boundaries
        bus(1'b0, 16'(BASE + 40), 16'h0);
        chk("oob_40", 32'(rdy), 0);
        bus(1'b0, 16'(BASE + 8), 16'h0);
        chk("oob_8", 32'(rdy), 0);
        bus(1'b0, 16'(BASE - 1), 16'h0);
        chk("oob_below", 32'(rdy), 0);
        rd_reg(7, 16'h0000, "last_reg");
        @(negedge I_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
Parametrised interrupt controller with NUM_TIMERS countdown timers and NUM_EXT external interrupt lines, register-mapped on the core's memory bus. It replaces the fixed single-timer, fixed-priority interrupt logic in the system top level. It provides pending/mask registers, one-shot or auto-reload timers and a deterministic acknowledge handshake that returns the serviced IRQ number.

Parameters:
NUM_TIMERS, 2, number of timer channels (1..8)
NUM_EXT, 2, number of external IRQ inputs (1..8); NUM_EXT+NUM_TIMERS <= WIDTH
WIDTH, 16, data width, timer counter width
BASE_ADDR, 16'hFF10, word address of register 0; map occupies 4+2*NUM_TIMERS words

Ports:
I_clk  in  1  clock
I_reset  in  1  synchronous, active-high reset
I_exec  in  1  bus access strobe, one cycle
I_write  in  1  1=write, 0=read; sampled with I_exec
I_addr  in  16  bus word address
I_data  in  WIDTH  write data
O_data  out  WIDTH  read data, valid when O_data_ready=1
O_data_ready  out  1  one-cycle completion pulse for an accepted access
I_ext_irq  in  NUM_EXT  external IRQ requests, level in, rising-edge sensitive
I_irq_ack  in  1  core acknowledge pulse
O_irq_active  out  1  any unmasked pending source
O_irq_num  out  8  serviced IRQ number, valid with O_irq_num_valid
O_irq_num_valid  out  1  one-cycle pulse, cycle after I_irq_ack

Behaviour:
- Reset: all outputs 0; PENDING=0, MASK=0 (all masked), ENABLE=0, MODE=0, all COUNT/RELOAD=0; edge-detect history=0.
- Sources: index s<NUM_EXT is external s; index NUM_EXT+i is timer i. IRQ number = s+1; 0 means none. Lower index = higher priority.
- Register offsets (from BASE_ADDR): 0 PENDING (R, write-1-to-clear), 1 MASK (RW, 1=enabled), 2 TIMER_ENABLE (RW, bit i), 3 TIMER_MODE (RW, bit i: 0 one-shot, 1 auto-reload), 4+2i TIMERi_RELOAD (RW), 5+2i TIMERi_COUNT (RW). Bits above the source/timer count read 0 and ignore writes.
- Bus: I_exec with address in map -> access accepted; O_data_ready=1 exactly next cycle; O_data holds read value that cycle (0 for writes). Address outside map: ignored, no O_data_ready. Address in map above last register: read 0, write ignored, O_data_ready still pulses.
- Writing TIMERi_RELOAD also loads TIMERi_COUNT with the same value.
- External: pending bit set on 0->1 transition of I_ext_irq[s] (registered previous value). A held-high level sets it once.
- Timer i, each cycle with ENABLE[i]=1 and COUNT>0: COUNT decrements. Expiry when COUNT==1: pending set, COUNT <= RELOAD in auto-reload mode, else 0. COUNT==0 stays idle; RELOAD==0 in auto-reload mode stops after one expiry. ENABLE=0 freezes COUNT. A bus write to COUNT in the same cycle overrides the decrement.
- O_irq_active = |(PENDING & MASK), registered-state combinational, no extra latency.
- Ack: on I_irq_ack, select the lowest-index set bit of PENDING & MASK. Next cycle O_irq_num=s+1, O_irq_num_valid=1, that PENDING bit cleared. No unmasked pending source -> O_irq_num=0, valid still pulses. O_irq_num holds its value until the next ack.
- Simultaneous events: a new source set in the same cycle as an ack clear or W1C clear of the same bit wins (bit stays 1). Ack and bus access in the same cycle are both serviced.
- Masked sources still latch into PENDING.
- Reset mid-count or mid-ack: everything returns to reset values next cycle, and no O_irq_num_valid or O_data_ready is produced.

Decomposition:
- Package timer_irq_pkg: register offset constants (REG_PENDING, REG_MASK, REG_TIMER_ENABLE, REG_TIMER_MODE, REG_TIMER_BASE) and the IRQ_NONE=0 constant. The top-level mmap.vh gets the BASE_ADDR entry.
- Sub-module timer_channel (WIDTH): count/reload/mode/enable inputs and load strobe; outputs COUNT and a one-cycle expire pulse. Instantiated NUM_TIMERS times by generate. Priority encoder and bus decode stay in the top.

Test Plan:
- Reset, then read MASK and PENDING -> both 0, O_data_ready one cycle after each I_exec; O_irq_active=0.
- MASK=16'h000F, TIMER0_RELOAD=5, MODE=0, ENABLE=1 -> PENDING bit 2 set exactly 5 cycles after enable write completes; O_irq_active=1; COUNT reads 0 afterwards and no second expiry within 20 cycles.
- TIMER1 auto-reload, RELOAD=3 -> PENDING bit 3 set every 3 cycles. W1C clear of bit 3 in the cycle of a new expiry -> bit remains 1.
- Pulse I_ext_irq[1] and I_ext_irq[0] together with MASK=3 -> O_irq_active=1. First ack gives O_irq_num=1, second gives 2, third gives 0; O_irq_num_valid pulses 3 times; O_irq_active=0 at end.
- Hold I_ext_irq[0] high for 10 cycles -> single pending set. With MASK=0 -> PENDING=1, O_irq_active=0, ack returns 0.
- Assert I_reset while TIMER0 counts at COUNT=3 -> next cycle COUNT=0, PENDING=0, no expiry; access to BASE_ADDR+40 gives no O_data_ready.
